// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial word serializer and the bit-serial
// checkers it feeds.
package serial_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Width of a down-counter that must hold values 0..w.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_word_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word over valid/ready and
// emits it MSB first, one bit per output transfer, with first/last markers.
module serial_word_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic             out_bit,
   output logic             out_first,
   output logic             out_last,
   input  logic             out_ready
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_TOP  = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t           state_r, state_nxt_s;
   logic [WIDTH-1:0] sh_r, sh_nxt_s;
   logic [CW-1:0]    cnt_r, cnt_nxt_s;
   logic             in_xfer_s;
   logic             out_xfer_s;
   logic             cnt_zero_s;

   // Handshake and output decode; in_ready reacts combinationally to out_ready
   // so a new word can follow the last bit without a bubble.
   always_comb begin
      cnt_zero_s = (cnt_r == CNT_ZERO);
      out_valid  = (state_r == SHIFT);
      in_ready   = !rst && ((state_r == IDLE) ||
                            ((state_r == SHIFT) && cnt_zero_s && out_ready));
      in_xfer_s  = in_valid && in_ready;
      out_xfer_s = out_valid && out_ready;
      out_bit    = out_valid && sh_r[WIDTH-1];
      out_first  = out_valid && (cnt_r == CNT_TOP);
      out_last   = out_valid && cnt_zero_s;
   end

   // Next-state logic: load on input transfer, shift on output transfer, else hold.
   always_comb begin
      state_nxt_s = state_r;
      sh_nxt_s    = sh_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (in_xfer_s) begin
               state_nxt_s = SHIFT;
               sh_nxt_s    = in_data;
               cnt_nxt_s   = CNT_TOP;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            if (out_xfer_s && !cnt_zero_s) begin
               sh_nxt_s  = sh_r << 1;
               cnt_nxt_s = cnt_r - CNT_ONE;
            end else if (out_xfer_s && in_xfer_s) begin
               sh_nxt_s  = in_data;
               cnt_nxt_s = CNT_TOP;
            end else if (out_xfer_s) begin
               state_nxt_s = IDLE;
               sh_nxt_s    = {WIDTH{1'b0}};
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            sh_nxt_s    = {WIDTH{1'b0}};
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // State, shift register and bit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         sh_r    <= {WIDTH{1'b0}};
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_nxt_s;
         sh_r    <= sh_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

endmodule

// File: tb/tb_serial_word_serializer.sv
// Directed bench for serial_word_serializer: an 8-bit and a 1-bit instance.
module tb_serial_word_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       iv8, ir8, ov8, ob8, of8, ol8, or8;
   logic [7:0] id8;
   logic       iv1, ir1, ov1, ob1, of1, ol1, or1;
   logic [0:0] id1;
   int         n_assert = 0;
   int         n_fail   = 0;
   logic       d5;

   always #5 clk = ~clk;

   serial_word_serializer #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
      .out_valid(ov8), .out_bit(ob8), .out_first(of8), .out_last(ol8),
      .out_ready(or8));

   serial_word_serializer #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
      .out_valid(ov1), .out_bit(ob1), .out_first(of1), .out_last(ol1),
      .out_ready(or1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic v, input logic b,
                       input logic f, input logic l, input logic r);
      #1;
      chk({tag, ".valid"}, ov8, v);
      chk({tag, ".bit"},   ob8, b);
      chk({tag, ".first"}, of8, f);
      chk({tag, ".last"},  ol8, l);
      chk({tag, ".ready"}, ir8, r);
   endtask

   task automatic chk1(input string tag, input logic v, input logic b,
                       input logic f, input logic l, input logic r);
      #1;
      chk({tag, ".valid"}, ov1, v);
      chk({tag, ".bit"},   ob1, b);
      chk({tag, ".first"}, of1, f);
      chk({tag, ".last"},  ol1, l);
      chk({tag, ".ready"}, ir1, r);
   endtask

   // Sends one word through dut8, checking every cycle; optional 2-cycle stall
   // at bit index stall_at. Returns divisibility-by-5 of the observed stream.
   task automatic send8(input string tag, input logic [7:0] w,
                        input int stall_at, output logic div5);
      int   rem;
      logic b;
      rem = 0;
      iv8 = 1'b1;
      id8 = w;
      chk8($sformatf("%s.acc", tag), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      iv8 = 1'b0;
      id8 = 8'h00;
      for (int i = 0; i < 8; i++) begin
         b = w[7-i];
         if (i == stall_at) begin
            or8 = 1'b0;
            for (int s = 0; s < 2; s++) begin
               chk8($sformatf("%s.stall%0d", tag, s), 1'b1, b,
                    (i == 0), (i == 7), 1'b0);
               tick();
            end
            or8 = 1'b1;
         end
         chk8($sformatf("%s.b%0d", tag, i), 1'b1, b, (i == 0), (i == 7), (i == 7));
         rem = (i == 0) ? int'(ob8) : ((rem * 2 + int'(ob8)) % 5);
         tick();
      end
      div5 = (rem == 0);
      chk8($sformatf("%s.idle", tag), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [7:0] wa, wb;
      rst = 1'b1;
      iv8 = 1'b0; id8 = 8'h00; or8 = 1'b1;
      iv1 = 1'b0; id1 = 1'b0;  or1 = 1'b1;
      tick();
      tick();
      chk8("rst8", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk1("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      chk8("rel8", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk1("rel1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      send8("a5", 8'hA5, -1, d5);

      // Back-to-back 0F then F0 with in_valid held; second load on the last bit.
      wa = 8'h0F;
      wb = 8'hF0;
      iv8 = 1'b1;
      id8 = wa;
      chk8("b2b.acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      id8 = wb;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) begin
            iv8 = 1'b0;
            id8 = 8'h00;
         end
         chk8($sformatf("b2b.c%0d", i), 1'b1,
              (i < 8) ? wa[7-(i%8)] : wb[7-(i%8)],
              (i % 8 == 0), (i % 8 == 7), (i % 8 == 7));
         tick();
      end
      chk8("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      send8("bp3c", 8'h3C, 3, d5);

      // Reset while bit 4 of FF is on the line.
      iv8 = 1'b1;
      id8 = 8'hFF;
      chk8("rmw.acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      iv8 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk8($sformatf("rmw.b%0d", i), 1'b1, 1'b1, (i == 0), 1'b0, 1'b0);
         tick();
      end
      rst = 1'b1;
      chk8("rmw.b4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk8("rmw.inrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      chk8("rmw.rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      send8("w01", 8'h01, -1, d5);

      send8("d25", 8'd25, -1, d5);
      chk("div5.25", d5, 1'b1);
      send8("d26", 8'd26, -1, d5);
      chk("div5.26", d5, 1'b0);
      send8("d0", 8'd0, -1, d5);
      chk("div5.0", d5, 1'b1);
      send8("d255", 8'd255, -1, d5);
      chk("div5.255", d5, 1'b1);

      // WIDTH=1 words 1,0,1 back-to-back.
      iv1 = 1'b1;
      id1 = 1'b1;
      chk1("w1.acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      id1 = 1'b0;
      chk1("w1.c0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      id1 = 1'b1;
      chk1("w1.c1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      iv1 = 1'b0;
      chk1("w1.c2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      chk1("w1.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
